lsu_mem_stage: RTL
==================

Name: lsu_mem_stage

Overview:
- Load/store unit for the MEM stage of the 5-stage RV64 pipeline, directly downstream of the EX/MEM register.
- Turns the EX/MEM access (address, store data, funct3, memread/memwrite) into a req/ack transaction on a variable-latency data-memory bus.
- Stalls the pipeline while the access is outstanding.
- Returns aligned, sign/zero-extended load data to the MEM/WB register.

Parameters:
- TIMEOUT, 16, max WAIT cycles before the access is aborted with bus_err.
- CNT_W, 5, timeout counter width; must hold TIMEOUT.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX/MEM holds a valid instruction.
- ex_memread  in  1  load.
- ex_memwrite  in  1  store.
- ex_funct3  in  3  size/sign: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
- ex_addr  in  64  byte address (exmem ALU result).
- ex_wdata  in  64  store data, right-justified.
- mem_req  out  1  bus request, registered.
- mem_we  out  1  1 = write.
- mem_addr  out  64  ex_addr with [2:0] cleared.
- mem_be  out  8  byte enables.
- mem_wdata  out  64  lane-shifted store data.
- mem_ack  in  1  one-cycle completion pulse; mem_rdata valid with it.
- mem_rdata  in  64  doubleword read data.
- stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM.
- load_data  out  64  extended load result to MEM/WB.
- load_valid  out  1  load_data valid (1-cycle pulse).
- acc_err  out  1  misaligned/illegal access (1-cycle pulse).
- bus_err  out  1  timeout abort (1-cycle pulse).

Behaviour:
- Reset (reset=0, async): state IDLE. mem_req, mem_we, mem_addr, mem_be, mem_wdata, load_data, load_valid, acc_err, bus_err and the counter all go to 0 immediately. stall=0. A mid-transaction reset abandons it, and mem_req drops without waiting for ack.
- start = ex_valid & (ex_memread ^ ex_memwrite).
- Illegal in IDLE:
  - ex_valid with memread & memwrite both 1.
  - Load with funct3=111, or store with funct3[2]=1.
  - Misaligned: h with addr[0]; w/wu with addr[1:0]≠0; d with addr[2:0]≠0.
  - Response: acc_err=1 next cycle for 1 cycle, no bus request, no stall, state stays IDLE.
- FSM IDLE / WAIT / DONE:
  - IDLE, legal start: register mem_req=1, mem_we=ex_memwrite, mem_addr, mem_be, mem_wdata; clear counter; go to WAIT.
  - WAIT: bus outputs held stable; counter increments each cycle.
    - mem_ack=1: drop mem_req, go to DONE. For loads, register load_data.
    - Otherwise, when counter reaches TIMEOUT: drop mem_req, load_data=0, go to DONE, bus_err=1 in the DONE cycle.
  - DONE: lasts 1 cycle. load_valid=1 if the access was a load. Inputs are ignored (EX/MEM still holds the completing instruction). Always returns to IDLE.
- Stall: combinational. stall = (IDLE & start & legal) | WAIT. stall=0 in DONE.
- Minimum latency (ack in first WAIT cycle):
  - Cycle 0: IDLE, stall=1.
  - Cycle 1: WAIT, mem_req=1, ack.
  - Cycle 2: DONE, load_valid=1.
  - Total: 2 stall cycles.
- An ack arriving outside WAIT is ignored.
- Store lanes, with off=addr[2:0]:
  - b: be=0x01<<off, wdata = byte replicated ×8.
  - h: be=0x03<<off, halfword ×4.
  - w: be=0x0F<<off, word ×2.
  - d: be=0xFF, wdata as given.
- Load extraction: s = mem_rdata >> (8*off). Then:
  - b: sext s[7:0]; bu: zext s[7:0].
  - h: sext s[15:0]; hu: zext s[15:0].
  - w: sext s[31:0]; wu: zext s[31:0].
  - d: s.
- load_data holds its value until the next load completes, a timeout occurs, or reset.

Test Plan:
- ld @0x40, ack on first WAIT cycle, rdata=0x1122334455667788 -> stall high 2 cycles; mem_be=0xFF, mem_addr=0x40; DONE: load_valid=1, load_data=0x1122334455667788.
- lb @0x43 with rdata byte3=0x80 -> load_data=0xFFFFFFFFFFFFFF80; lbu same -> 0x80; lhu @0x46 rdata[63:48]=0xBEEF -> 0xBEEF.
- sh @0x12 wdata=0xABCD -> mem_we=1, mem_addr=0x10, mem_be=0x0C, mem_wdata=0xABCDABCDABCDABCD; ack after 5 cycles -> stall high 6 cycles, load_valid stays 0.
- lw @0x22 -> acc_err 1-cycle pulse, mem_req never rises, stall=0; memread&memwrite both set -> same response.
- TIMEOUT=16, ld with no ack -> mem_req drops after 16 WAIT cycles, bus_err=1, load_valid=1, load_data=0, back to IDLE.
- reset to 0 in the third WAIT cycle -> mem_req, stall, all outputs 0 asynchronously; after release a new sd completes normally.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// ---------------------------------------------------------------------------
// lsu_mem_stage
//
// MEM-stage load/store unit for the 5-stage RV64 pipeline. Converts the
// EX/MEM access into a single req/ack transaction on a variable-latency
// data-memory bus, stalls the pipeline while it is outstanding and returns
// aligned, extended load data to MEM/WB.
//
// Handshake: mem_req rises one cycle after a legal access is seen in IDLE and
// stays high, with all bus fields stable, until the cycle in which mem_ack is
// sampled high (or the timeout expires). mem_ack is a one-cycle pulse that
// carries mem_rdata and is only honoured in WAIT.
//
// Ports:
//   clk, reset           clock, asynchronous active-low reset
//   ex_*                 EX/MEM access (valid, memread, memwrite, funct3,
//                        byte address, right-justified store data)
//   mem_req/we/addr/be/wdata   registered bus request fields
//   mem_ack, mem_rdata   bus completion pulse and doubleword read data
//   stall                combinational pipeline hold
//   load_data/load_valid extended load result and its 1-cycle strobe
//   acc_err              1-cycle pulse for misaligned/illegal accesses
//   bus_err              1-cycle pulse when the access times out
// ---------------------------------------------------------------------------
module lsu_mem_stage #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ex_valid,
    input  logic        ex_memread,
    input  logic        ex_memwrite,
    input  logic [2:0]  ex_funct3,
    input  logic [63:0] ex_addr,
    input  logic [63:0] ex_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_be,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic        stall,
    output logic [63:0] load_data,
    output logic        load_valid,
    output logic        acc_err,
    output logic        bus_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic        is_load_q, is_load_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [2:0]  off_q, off_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [63:0] mem_addr_q, mem_addr_d;
    logic [7:0]  mem_be_q, mem_be_d;
    logic [63:0] mem_wdata_q, mem_wdata_d;
    logic [63:0] load_data_q, load_data_d;
    logic        load_valid_q, load_valid_d;
    logic        acc_err_q, acc_err_d;
    logic        bus_err_q, bus_err_d;

    logic        start;
    logic        legal;
    logic        f3_ok;
    logic        align_ok;
    logic        illegal_evt;
    logic [2:0]  off;
    logic [7:0]  be_calc;
    logic [63:0] wdata_calc;
    logic [63:0] shifted;
    logic [63:0] ext_data;
    logic [CNT_W-1:0] cnt_inc;

    assign off   = ex_addr[2:0];
    assign start = ex_valid & (ex_memread ^ ex_memwrite);

    // Decode legality of the access currently presented by EX/MEM.
    always_comb begin
        f3_ok = ex_memread ? (ex_funct3 != 3'b111) : ~ex_funct3[2];
        case (ex_funct3[1:0])
            2'b00:   align_ok = 1'b1;
            2'b01:   align_ok = ~off[0];
            2'b10:   align_ok = (off[1:0] == 2'b00);
            default: align_ok = (off == 3'b000);
        endcase
        legal       = f3_ok & align_ok;
        illegal_evt = ex_valid & ((ex_memread & ex_memwrite) | (start & ~legal));
    end

    // Byte-lane placement: data is replicated across all lanes so the
    // enables alone select where it lands.
    always_comb begin
        case (ex_funct3[1:0])
            2'b00: begin
                be_calc    = 8'h01 << off;
                wdata_calc = {8{ex_wdata[7:0]}};
            end
            2'b01: begin
                be_calc    = 8'h03 << off;
                wdata_calc = {4{ex_wdata[15:0]}};
            end
            2'b10: begin
                be_calc    = 8'h0F << off;
                wdata_calc = {2{ex_wdata[31:0]}};
            end
            default: begin
                be_calc    = 8'hFF;
                wdata_calc = ex_wdata;
            end
        endcase
    end

    // Load extraction uses the offset/size captured at request time.
    always_comb begin
        shifted = mem_rdata >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  ext_data = {{56{shifted[7]}}, shifted[7:0]};
            3'b100:  ext_data = {56'd0, shifted[7:0]};
            3'b001:  ext_data = {{48{shifted[15]}}, shifted[15:0]};
            3'b101:  ext_data = {48'd0, shifted[15:0]};
            3'b010:  ext_data = {{32{shifted[31]}}, shifted[31:0]};
            3'b110:  ext_data = {32'd0, shifted[31:0]};
            default: ext_data = shifted;
        endcase
    end

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        is_load_d    = is_load_q;
        funct3_d     = funct3_q;
        off_d        = off_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        acc_err_d    = 1'b0;
        bus_err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (illegal_evt) begin
                    acc_err_d = 1'b1;
                end else if (start) begin
                    state_d     = S_WAIT;
                    cnt_d       = '0;
                    is_load_d   = ex_memread;
                    funct3_d    = ex_funct3;
                    off_d       = off;
                    mem_req_d   = 1'b1;
                    mem_we_d    = ex_memwrite;
                    mem_addr_d  = {ex_addr[63:3], 3'b000};
                    mem_be_d    = be_calc;
                    mem_wdata_d = wdata_calc;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (mem_ack) begin
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    if (is_load_q) begin
                        load_data_d = ext_data;
                    end
                    load_valid_d = is_load_q;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    state_d      = S_DONE;
                    mem_req_d    = 1'b0;
                    load_data_d  = '0;
                    bus_err_d    = 1'b1;
                    load_valid_d = is_load_q;
                end
            end
            default: begin
                // DONE: EX/MEM still holds the completing instruction.
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            is_load_q    <= 1'b0;
            funct3_q     <= 3'b000;
            off_q        <= 3'b000;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            acc_err_q    <= 1'b0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            is_load_q    <= is_load_d;
            funct3_q     <= funct3_d;
            off_q        <= off_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            acc_err_q    <= acc_err_d;
            bus_err_q    <= bus_err_d;
        end
    end

    // Gated by reset so an in-flight EX/MEM access cannot hold the pipeline
    // while the unit is being reset.
    assign stall = reset & (((state_q == S_IDLE) & start & legal) | (state_q == S_WAIT));

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign acc_err    = acc_err_q;
    assign bus_err    = bus_err_q;

endmodule
